// File: rtl/mem_arbiter.sv
// Byte-wide RAM port arbiter for IF and MEM requesters; words split into byte beats.
// Optional IF abort path enabled by defining MEM_ARB_IF_FLUSH_EN.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter bit PRIO_MEM = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
`ifdef MEM_ARB_IF_FLUSH_EN
    input  logic              if_flush_i,
`endif
    output logic [31:0]       if_data_o,
    output logic              if_done_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [1:0]        mem_len_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_req_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, HOLD} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [1:0]        len_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rbuf;
    logic              last_mem;

    logic              flush;
    logic              if_ok;
    logic              grant_if, grant_mem;
    logic              busy, last_beat, abort;
    logic [2:0]        n_bytes;
    logic [1:0]        bidx;
    logic [31:0]       rnext, rword;

`ifdef MEM_ARB_IF_FLUSH_EN
    assign flush = if_flush_i;
`else
    assign flush = 1'b0;
`endif

    assign if_ok       = if_req_i & ~flush;
    assign stall_req_o = mem_req_i & ~mem_done_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_mem)     state_nxt = MEM_BUSY;
                else if (grant_if) state_nxt = IF_BUSY;
            end
            IF_BUSY:  if (abort || last_beat) state_nxt = HOLD;
            MEM_BUSY: if (last_beat) state_nxt = HOLD;
            default:  state_nxt = IDLE;
        endcase
    end

    // Grant decode and beat bookkeeping
    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state == IDLE) begin
            if (mem_req_i && if_ok) begin
                if (PRIO_MEM || !last_mem) grant_mem = 1'b1;
                else                       grant_if  = 1'b1;
            end else begin
                grant_mem = mem_req_i;
                grant_if  = if_ok;
            end
        end
        case (len_q)
            2'b00:   n_bytes = 3'd1;
            2'b01:   n_bytes = 3'd2;
            default: n_bytes = 3'd4;
        endcase
        busy      = (state == IF_BUSY) || (state == MEM_BUSY);
        last_beat = busy && (cnt == n_bytes);
        abort     = (state == IF_BUSY) && flush;
    end

    // cnt==4 maps to byte lane 3 through the 2-bit wrap
    always_comb begin
        bidx  = cnt[1:0] - 2'd1;
        rnext = rbuf;
        rnext[{bidx, 3'b000} +: 8] = ram_din_i;
        case (len_q)
            2'b00:   rword = {24'd0, rnext[7:0]};
            2'b01:   rword = {16'd0, rnext[15:0]};
            default: rword = rnext;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= 3'd0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            len_q       <= 2'b00;
            wdata_q     <= 32'd0;
            rbuf        <= 32'd0;
            last_mem    <= 1'b0;
            if_data_o   <= 32'd0;
            if_done_o   <= 1'b0;
            mem_rdata_o <= 32'd0;
            mem_done_o  <= 1'b0;
            ram_addr_o  <= '0;
            ram_wr_o    <= 1'b0;
            ram_dout_o  <= 8'd0;
        end else begin
            if_done_o  <= 1'b0;
            mem_done_o <= 1'b0;
            if (grant_if || grant_mem) begin
                addr_q     <= grant_mem ? mem_addr_i : if_addr_i;
                we_q       <= grant_mem & mem_we_i;
                len_q      <= grant_mem ? mem_len_i : 2'b11;
                wdata_q    <= mem_wdata_i;
                rbuf       <= 32'd0;
                cnt        <= 3'd1;
                last_mem   <= grant_mem;
                ram_addr_o <= grant_mem ? mem_addr_i : if_addr_i;
                ram_wr_o   <= grant_mem & mem_we_i;
                if (grant_mem && mem_we_i) ram_dout_o <= mem_wdata_i[7:0];
            end else if (busy) begin
                if (abort) begin
                    ram_wr_o <= 1'b0;
                    cnt      <= 3'd0;
                end else if (last_beat) begin
                    ram_wr_o <= 1'b0;
                    cnt      <= 3'd0;
                    if (state == IF_BUSY) begin
                        if_done_o <= 1'b1;
                        if_data_o <= rword;
                    end else begin
                        mem_done_o <= 1'b1;
                        if (!we_q) mem_rdata_o <= rword;
                    end
                end else begin
                    rbuf       <= rnext;
                    ram_addr_o <= addr_q + ADDR_W'(cnt);
                    if (we_q) ram_dout_o <= wdata_q[{cnt[1:0], 3'b000} +: 8];
                    cnt        <= cnt + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: main instance PRIO_MEM=1, second instance PRIO_MEM=0.
// Define MEM_ARB_IF_FLUSH_EN to also exercise the IF flush path.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, flush;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic [31:0] if_data, mem_rdata, ram_addr;
    logic        if_done, mem_done, stall, ram_wr;
    logic [7:0]  ram_dout, ram_din;

    logic        a_if_req, a_mem_req;
    logic [31:0] a_if_data, a_mem_rdata, a_ram_addr;
    logic        a_if_done, a_mem_done, a_stall, a_ram_wr;
    logic [7:0]  a_ram_dout, a_ram_din;

    logic [7:0]  ram [0:4095];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign ram_din   = ram[ram_addr[11:0]];
    assign a_ram_din = ram[a_ram_addr[11:0]];

    mem_arbiter #(.ADDR_W(32), .PRIO_MEM(1'b1)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr),
`ifdef MEM_ARB_IF_FLUSH_EN
        .if_flush_i(flush),
`endif
        .if_data_o(if_data), .if_done_o(if_done),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
        .stall_req_o(stall),
        .ram_addr_o(ram_addr), .ram_wr_o(ram_wr),
        .ram_dout_o(ram_dout), .ram_din_i(ram_din)
    );

    mem_arbiter #(.ADDR_W(32), .PRIO_MEM(1'b0)) alt (
        .clk(clk), .rst(rst),
        .if_req_i(a_if_req), .if_addr_i(if_addr),
`ifdef MEM_ARB_IF_FLUSH_EN
        .if_flush_i(1'b0),
`endif
        .if_data_o(a_if_data), .if_done_o(a_if_done),
        .mem_req_i(a_mem_req), .mem_we_i(mem_we), .mem_len_i(mem_len),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(a_mem_rdata), .mem_done_o(a_mem_done),
        .stall_req_o(a_stall),
        .ram_addr_o(a_ram_addr), .ram_wr_o(a_ram_wr),
        .ram_dout_o(a_ram_dout), .ram_din_i(a_ram_din)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (ram_wr !== 1'b0 || ram_addr !== 32'd0 || ram_dout !== 8'd0) begin
            failures++;
            $display("FAIL reset_ram got wr=%b addr=%h dout=%h exp 0", ram_wr, ram_addr, ram_dout);
        end
        checks++;
        if (if_done !== 1'b0 || mem_done !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got if=%b mem=%b stall=%b exp 0", if_done, mem_done, stall);
        end
        checks++;
        if (if_data !== 32'd0 || mem_rdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got if=%h mem=%h exp 0", if_data, mem_rdata);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_if_read();
        if_addr = 32'h100;
        if_req  = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ram_addr !== 32'h100 + i || if_done !== 1'b0) begin
                failures++;
                $display("FAIL if_beat%0d got addr=%h done=%b exp addr=%h done=0",
                         i, ram_addr, if_done, 32'h100 + i);
            end
            tick();
        end
        checks++;
        if (if_done !== 1'b1 || if_data !== 32'h0000_0513) begin
            failures++;
            $display("FAIL if_done got done=%b data=%h exp 1 00000513", if_done, if_data);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_done !== 1'b0) begin
            failures++;
            $display("FAIL if_pulse got done=%b exp 0", if_done);
        end
    endtask

    task automatic test_priority();
        int n;
        mem_we   = 1'b0;
        mem_len  = 2'b00;
        mem_addr = 32'h10;
        if_addr  = 32'h100;
        if_req   = 1'b1;
        mem_req  = 1'b1;
        tick();
        checks++;
        if (ram_addr !== 32'h10) begin
            failures++;
            $display("FAIL prio_grant got addr=%h exp 00000010", ram_addr);
        end
        tick();
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h34 || if_done !== 1'b0) begin
            failures++;
            $display("FAIL prio_memdone got done=%b data=%h ifd=%b exp 1 00000034 0",
                     mem_done, mem_rdata, if_done);
        end
        mem_req = 1'b0;
        tick();
        checks++;
        if (ram_addr !== 32'h10) begin
            failures++;
            $display("FAIL prio_hold got addr=%h exp 00000010", ram_addr);
        end
        tick();
        checks++;
        if (ram_addr !== 32'h100) begin
            failures++;
            $display("FAIL prio_ifgrant got addr=%h exp 00000100", ram_addr);
        end
        n = 0;
        while (if_done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4 || if_data !== 32'h0000_0513) begin
            failures++;
            $display("FAIL prio_ifdone got cycles=%0d data=%h exp 4 00000513", n, if_data);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_alternate();
        int n;
        mem_we    = 1'b0;
        mem_len   = 2'b00;
        mem_addr  = 32'h10;
        if_addr   = 32'h100;
        a_if_req  = 1'b1;
        a_mem_req = 1'b1;
        tick();
        checks++;
        if (a_ram_addr !== 32'h10) begin
            failures++;
            $display("FAIL alt_first got addr=%h exp 00000010", a_ram_addr);
        end
        tick();
        checks++;
        if (a_mem_done !== 1'b1 || a_mem_rdata !== 32'h34) begin
            failures++;
            $display("FAIL alt_memdone got done=%b data=%h exp 1 00000034", a_mem_done, a_mem_rdata);
        end
        a_if_req  = 1'b0;
        a_mem_req = 1'b0;
        tick();
        a_if_req  = 1'b1;
        a_mem_req = 1'b1;
        tick();
        checks++;
        if (a_ram_addr !== 32'h100) begin
            failures++;
            $display("FAIL alt_second got addr=%h exp 00000100", a_ram_addr);
        end
        n = 0;
        while (a_if_done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4 || a_if_data !== 32'h0000_0513) begin
            failures++;
            $display("FAIL alt_ifdone got cycles=%0d data=%h exp 4 00000513", n, a_if_data);
        end
        a_if_req  = 1'b0;
        a_mem_req = 1'b0;
        tick();
    endtask

    task automatic test_byte_write();
        mem_we    = 1'b1;
        mem_len   = 2'b00;
        mem_addr  = 32'h20004;
        mem_wdata = 32'h1234_56AB;
        mem_req   = 1'b1;
        tick();
        checks++;
        if (ram_wr !== 1'b1 || ram_addr !== 32'h20004 || ram_dout !== 8'hAB ||
            mem_done !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL bw_beat got wr=%b addr=%h dout=%h done=%b stall=%b exp 1 00020004 ab 0 1",
                     ram_wr, ram_addr, ram_dout, mem_done, stall);
        end
        tick();
        checks++;
        if (ram_wr !== 1'b0 || mem_done !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL bw_done got wr=%b done=%b stall=%b exp 0 1 0", ram_wr, mem_done, stall);
        end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
    endtask

    task automatic test_half_read();
        mem_we   = 1'b0;
        mem_len  = 2'b01;
        mem_addr = 32'h10;
        mem_req  = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL hr_stall0 got %b exp 1", stall);
        end
        tick();
        checks++;
        if (ram_addr !== 32'h10 || stall !== 1'b1) begin
            failures++;
            $display("FAIL hr_t0 got addr=%h stall=%b exp 00000010 1", ram_addr, stall);
        end
        tick();
        checks++;
        if (ram_addr !== 32'h11 || stall !== 1'b1 || mem_done !== 1'b0) begin
            failures++;
            $display("FAIL hr_t1 got addr=%h stall=%b done=%b exp 00000011 1 0",
                     ram_addr, stall, mem_done);
        end
        tick();
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h0000_1234 || stall !== 1'b0) begin
            failures++;
            $display("FAIL hr_done got done=%b data=%h stall=%b exp 1 00001234 0",
                     mem_done, mem_rdata, stall);
        end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_wrap_and_len10();
        mem_we   = 1'b0;
        mem_len  = 2'b01;
        mem_addr = 32'hFFFF_FFFF;
        mem_req  = 1'b1;
        tick();
        tick();
        checks++;
        if (ram_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_addr got %h exp 00000000", ram_addr);
        end
        tick();
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h0000_5678) begin
            failures++;
            $display("FAIL wrap_data got done=%b data=%h exp 1 00005678", mem_done, mem_rdata);
        end
        mem_req = 1'b0;
        tick();
        mem_len  = 2'b10;
        mem_addr = 32'h100;
        mem_req  = 1'b1;
        repeat (4) tick();
        checks++;
        if (ram_addr !== 32'h103 || mem_done !== 1'b0) begin
            failures++;
            $display("FAIL len10_t3 got addr=%h done=%b exp 00000103 0", ram_addr, mem_done);
        end
        tick();
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h0000_0513) begin
            failures++;
            $display("FAIL len10_done got done=%b data=%h exp 1 00000513", mem_done, mem_rdata);
        end
        mem_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        mem_we    = 1'b1;
        mem_len   = 2'b11;
        mem_addr  = 32'h40;
        mem_wdata = 32'hDEAD_BEEF;
        mem_req   = 1'b1;
        tick();
        checks++;
        if (ram_wr !== 1'b1 || ram_addr !== 32'h40 || ram_dout !== 8'hEF) begin
            failures++;
            $display("FAIL rm_t0 got wr=%b addr=%h dout=%h exp 1 00000040 ef", ram_wr, ram_addr, ram_dout);
        end
        tick();
        checks++;
        if (ram_wr !== 1'b1 || ram_addr !== 32'h41 || ram_dout !== 8'hBE) begin
            failures++;
            $display("FAIL rm_t1 got wr=%b addr=%h dout=%h exp 1 00000041 be", ram_wr, ram_addr, ram_dout);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ram_wr !== 1'b0 || mem_done !== 1'b0) begin
            failures++;
            $display("FAIL rm_async got wr=%b done=%b exp 0 0", ram_wr, mem_done);
        end
        mem_req = 1'b0;
        mem_we  = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mem_done !== 1'b0 || ram_wr !== 1'b0) begin
                failures++;
                $display("FAIL rm_quiet%0d got done=%b wr=%b exp 0 0", i, mem_done, ram_wr);
            end
        end
        mem_len  = 2'b00;
        mem_addr = 32'h10;
        mem_req  = 1'b1;
        tick();
        checks++;
        if (ram_addr !== 32'h10) begin
            failures++;
            $display("FAIL rm_idle got addr=%h exp 00000010", ram_addr);
        end
        tick();
        checks++;
        if (mem_done !== 1'b1 || mem_rdata !== 32'h34) begin
            failures++;
            $display("FAIL rm_after got done=%b data=%h exp 1 00000034", mem_done, mem_rdata);
        end
        mem_req = 1'b0;
        tick();
    endtask

`ifdef MEM_ARB_IF_FLUSH_EN
    task automatic test_flush();
        int n;
        if_addr = 32'h100;
        if_req  = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        tick();
        checks++;
        if (if_done !== 1'b0 || ram_wr !== 1'b0 || ram_addr !== 32'h101) begin
            failures++;
            $display("FAIL fl_abort got done=%b wr=%b addr=%h exp 0 0 00000101", if_done, ram_wr, ram_addr);
        end
        flush = 1'b0;
        tick();
        checks++;
        if (if_done !== 1'b0 || ram_addr !== 32'h101) begin
            failures++;
            $display("FAIL fl_hold got done=%b addr=%h exp 0 00000101", if_done, ram_addr);
        end
        tick();
        checks++;
        if (ram_addr !== 32'h100) begin
            failures++;
            $display("FAIL fl_regrant got addr=%h exp 00000100", ram_addr);
        end
        n = 0;
        while (if_done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 4 || if_data !== 32'h0000_0513) begin
            failures++;
            $display("FAIL fl_done got cycles=%0d data=%h exp 4 00000513", n, if_data);
        end
        if_req = 1'b0;
        tick();
        flush  = 1'b1;
        if_req = 1'b1;
        tick();
        checks++;
        if (ram_addr !== 32'h103) begin
            failures++;
            $display("FAIL fl_idleblock got addr=%h exp 00000103", ram_addr);
        end
        flush = 1'b0;
        tick();
        checks++;
        if (ram_addr !== 32'h100) begin
            failures++;
            $display("FAIL fl_idlegrant got addr=%h exp 00000100", ram_addr);
        end
        n = 0;
        while (if_done !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if_req = 1'b0;
        tick();
    endtask
`endif

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h100] = 8'h13;
        ram[12'h101] = 8'h05;
        ram[12'h010] = 8'h34;
        ram[12'h011] = 8'h12;
        ram[12'hFFF] = 8'h78;
        ram[12'h000] = 8'h56;
        rst       = 1'b1;
        if_req    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        flush     = 1'b0;
        if_addr   = 32'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_len   = 2'b00;
        a_if_req  = 1'b0;
        a_mem_req = 1'b0;

        test_reset();
        test_if_read();
        test_priority();
        test_alternate();
        test_byte_write();
        test_half_read();
        test_wrap_and_len10();
        test_reset_mid();
`ifdef MEM_ARB_IF_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
